// File: rtl/fader_pkg.sv
// Shared types and constants for the full-screen image fader.
// Defining FADER_DITHER_EN adds the 4x4 ordered-dither table used by the top level.
package fader_pkg;

  typedef enum logic [1:0] {
    HIDDEN     = 2'd0,
    FADING_IN  = 2'd1,
    SHOWN      = 2'd2,
    FADING_OUT = 2'd3
  } fade_state_t;

  localparam int FADE_MAX = 16;
  localparam int LEVEL_W  = 5;

`ifdef FADER_DITHER_EN
  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };
`endif

  // Smallest r with (1 << r) >= v; used to turn screen/image ratios into shifts.
  function automatic int log2i(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fader_scale.sv
// One colour channel scaled by the fade level: (chan * level + dith) >> 4.
// Level 16 with any dith in 0..15 returns chan unchanged; level 0 returns 0.
module fader_scale
  import fader_pkg::*;
(
  input  logic [3:0]         chan,
  input  logic [LEVEL_W-1:0] level,
  input  logic [3:0]         dith,
  output logic [3:0]         scaled
);

  function automatic logic [3:0] scale_trunc(input logic [3:0]         c,
                                             input logic [LEVEL_W-1:0] l,
                                             input logic [3:0]         d);
    logic [8:0] prod;
    prod = 9'(c) * 9'(l) + 9'(d);
    return 4'(prod >> 4);
  endfunction

  assign scaled = scale_trunc(chan, level, dith);

endmodule

// File: rtl/fullscreen_image_fader.sv
// Full-screen indexed-image renderer with frame-synchronous fade-in/fade-out.
// Optional build macro FADER_DITHER_EN enables 4x4 ordered dithering of the fade.
module fullscreen_image_fader
  import fader_pkg::*;
#(
  parameter int IMG_W            = 160,
  parameter int IMG_H            = 120,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480,
  parameter int IDX_W            = 4,
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic                            vga_clk,
  input  logic                            reset,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic                            blank,
  input  logic                            show_req,
  input  logic                            hide_req,
  output logic [$clog2(IMG_W*IMG_H)-1:0]  rom_addr,
  input  logic [IDX_W-1:0]                rom_q,
  output logic [IDX_W-1:0]                pal_index,
  input  logic [11:0]                     pal_rgb,
  output logic [3:0]                      red,
  output logic [3:0]                      green,
  output logic [3:0]                      blue,
  output logic                            busy,
  output logic                            done,
  output logic [4:0]                      level
);

  localparam int ADDR_W  = $clog2(IMG_W*IMG_H);
  localparam int X_SHIFT = log2i(SCREEN_W / IMG_W);
  localparam int Y_SHIFT = log2i(SCREEN_H / IMG_H);
  localparam int STEP_W  = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

  localparam logic [9:0]        X_LAST    = 10'(SCREEN_W - 1);
  localparam logic [9:0]        Y_LAST    = 10'(SCREEN_H - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
  localparam logic [4:0]        LVL_MAX   = 5'(FADE_MAX);

  logic              in_rng;
  logic [9:0]        tex_x, tex_y;
  logic [ADDR_W-1:0] addr_nxt;

  assign in_rng   = (DrawX <= X_LAST) && (DrawY <= Y_LAST);
  assign tex_x    = DrawX >> X_SHIFT;
  assign tex_y    = DrawY >> Y_SHIFT;
  assign addr_nxt = in_rng ? (ADDR_W'(tex_y) * ADDR_W'(IMG_W) + ADDR_W'(tex_x)) : '0;

  // S1: texel address and the visibility flags that ride alongside it.
  // S2: the ROM returns rom_q one cycle later; the palette lookup is combinational.
  logic blank_p0, blank_p1, rng_p0, rng_p1;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr <= '0;
      blank_p0 <= 1'b0;
      rng_p0   <= 1'b0;
      blank_p1 <= 1'b0;
      rng_p1   <= 1'b0;
    end else begin
      rom_addr <= addr_nxt;
      blank_p0 <= blank;
      rng_p0   <= in_rng;
      blank_p1 <= blank_p0;
      rng_p1   <= rng_p0;
    end
  end

  assign pal_index = rom_q;

  logic [3:0] dith;

`ifdef FADER_DITHER_EN
  logic [1:0] dx_p0, dy_p0, dx_p1, dy_p1;

  always_ff @(posedge vga_clk) begin
    dx_p0 <= DrawX[1:0];
    dy_p0 <= DrawY[1:0];
    dx_p1 <= dx_p0;
    dy_p1 <= dy_p0;
  end

  assign dith = BAYER[dy_p1][dx_p1];
`else
  assign dith = 4'd0;
`endif

  logic [3:0] r_s, g_s, b_s;

  fader_scale u_scale_r (.chan(pal_rgb[11:8]), .level(level), .dith(dith), .scaled(r_s));
  fader_scale u_scale_g (.chan(pal_rgb[7:4]),  .level(level), .dith(dith), .scaled(g_s));
  fader_scale u_scale_b (.chan(pal_rgb[3:0]),  .level(level), .dith(dith), .scaled(b_s));

  // S3: scaled colour, forced black outside the visible image.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else if (blank_p1 && rng_p1) begin
      red   <= r_s;
      green <= g_s;
      blue  <= b_s;
    end else begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end
  end

  fade_state_t       state;
  logic [STEP_W-1:0] step_cnt;
  logic              fe, step_wrap;

  assign fe        = (DrawX == X_LAST) && (DrawY == Y_LAST);
  assign step_wrap = fe && (step_cnt == STEP_LAST);

  // A request that changes direction takes that cycle; level only moves on a step.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state    <= HIDDEN;
      level    <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fe) step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;

      if (hide_req && (state == FADING_IN || state == SHOWN)) begin
        state <= FADING_OUT;
        busy  <= 1'b1;
      end else if (!hide_req && show_req && state == HIDDEN) begin
        state    <= FADING_IN;
        busy     <= 1'b1;
        step_cnt <= '0;
      end else if (!hide_req && show_req && state == FADING_OUT) begin
        state <= FADING_IN;
        busy  <= 1'b1;
      end else if (step_wrap && state == FADING_IN) begin
        if (level >= LVL_MAX - 5'd1) begin
          level <= LVL_MAX;
          state <= SHOWN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          level <= level + 5'd1;
        end
      end else if (step_wrap && state == FADING_OUT) begin
        if (level <= 5'd1) begin
          level <= '0;
          state <= HIDDEN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          level <= level - 5'd1;
        end
      end
    end
  end

endmodule
